// File: rtl/alu_uart_if.sv
// Byte-stream front end for the combinational ALU: assembles A, B and op from UART bytes,
// then returns the result LSB first. Optional inter-byte timeout: define ALU_UART_IF_TIMEOUT_EN.
//
// state   | meaning
// RX_A    | collecting operand A bytes (idle when cnt == 0)
// RX_B    | collecting operand B bytes
// RX_OP   | waiting for the operation byte
// EXEC    | capture ALU result (inputs registered one cycle earlier)
// TX_SEND | present result byte cnt and pulse o_tx_start
// TX_WAIT | wait for the transmitter to finish the byte
module alu_uart_if #(
    parameter int NB_REG         = 32,
    parameter int NB_OP          = 6,
    parameter int NB_BYTE        = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    output logic [NB_REG-1:0]  o_alu_a,
    output logic [NB_REG-1:0]  o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_REG-1:0]  i_alu_result,
    output logic               o_busy
);

    localparam int NB_BYTES = NB_REG / NB_BYTE;
    localparam int CW       = $clog2(NB_BYTES) + 1;
    localparam logic [CW-1:0] LAST = CW'(NB_BYTES - 1);

    if (TIMEOUT_CYCLES < 2 || (NB_REG % NB_BYTE) != 0 || NB_OP > NB_BYTE) begin : g_param_check
        $error("alu_uart_if: illegal parameter combination");
    end

    typedef enum logic [2:0] {RX_A, RX_B, RX_OP, EXEC, TX_SEND, TX_WAIT} state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [NB_REG-1:0]  result;
    logic               idle_hit;

    assign o_busy = !(state == RX_A && cnt == '0);

`ifdef ALU_UART_IF_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] IDLE_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_tmr;
    logic          idle_active;

    assign idle_active = (state == RX_A && cnt != '0) || state == RX_B || state == RX_OP;
    assign idle_hit    = idle_active && !i_rx_valid && idle_tmr == '0;

    // Down-counter reloads on every byte and whenever the FSM leaves the receive phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idle_tmr <= IDLE_LOAD;
        end else if (!idle_active || i_rx_valid || idle_hit) begin
            idle_tmr <= IDLE_LOAD;
        end else begin
            idle_tmr <= idle_tmr - 1'b1;
        end
    end
`else
    assign idle_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= RX_A;
            cnt        <= '0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            result     <= '0;
        end else begin
            o_tx_start <= 1'b0;
            case (state)
                RX_A: if (i_rx_valid) begin
                    for (int i = 0; i < NB_BYTES; i++)
                        if (cnt == CW'(i)) o_alu_a[i*NB_BYTE +: NB_BYTE] <= i_rx_data;
                    if (cnt == LAST) begin
                        state <= RX_B;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_B: if (i_rx_valid) begin
                    for (int i = 0; i < NB_BYTES; i++)
                        if (cnt == CW'(i)) o_alu_b[i*NB_BYTE +: NB_BYTE] <= i_rx_data;
                    if (cnt == LAST) begin
                        state <= RX_OP;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_OP: if (i_rx_valid) begin
                    o_alu_op <= i_rx_data[NB_OP-1:0];
                    state    <= EXEC;
                    cnt      <= '0;
                end
                EXEC: begin
                    result <= i_alu_result;
                    state  <= TX_SEND;
                    cnt    <= '0;
                end
                // cnt carries the byte index across the TX_SEND/TX_WAIT loop
                TX_SEND: begin
                    for (int i = 0; i < NB_BYTES; i++)
                        if (cnt == CW'(i)) o_tx_data <= result[i*NB_BYTE +: NB_BYTE];
                    o_tx_start <= 1'b1;
                    state      <= TX_WAIT;
                end
                TX_WAIT: if (i_tx_done) begin
                    if (cnt == LAST) begin
                        state <= RX_A;
                        cnt   <= '0;
                    end else begin
                        state <= TX_SEND;
                        cnt   <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= RX_A;
                    cnt   <= '0;
                end
            endcase
            if (idle_hit) begin
                state <= RX_A;
                cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_alu_uart_if.sv
// Directed self-checking bench for alu_uart_if with a small MIPS-style ALU model as the load.
// Define ALU_UART_IF_TIMEOUT_EN to also exercise the inter-byte timeout.
module tb_alu_uart_if;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [7:0]  i_rx_data = '0;
    logic        i_rx_valid = 1'b0;
    logic        i_tx_done = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic [31:0] o_alu_a, o_alu_b, i_alu_result;
    logic [5:0]  o_alu_op;
    logic        o_busy;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_alu_result = '0;
        case (o_alu_op)
            6'h20: i_alu_result = o_alu_a + o_alu_b;
            6'h22: i_alu_result = o_alu_a - o_alu_b;
            6'h24: i_alu_result = o_alu_a & o_alu_b;
            6'h25: i_alu_result = o_alu_a | o_alu_b;
            6'h26: i_alu_result = o_alu_a ^ o_alu_b;
            6'h02: i_alu_result = o_alu_a >> o_alu_b[4:0];
            6'h2A: i_alu_result = {31'd0, $signed(o_alu_a) < $signed(o_alu_b)};
            default: i_alu_result = '0;
        endcase
    end

    alu_uart_if #(.NB_REG(32), .NB_OP(6), .NB_BYTE(8), .TIMEOUT_CYCLES(20)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid),
        .o_tx_data(o_tx_data), .o_tx_start(o_tx_start), .i_tx_done(i_tx_done),
        .o_alu_a(o_alu_a), .o_alu_b(o_alu_b), .o_alu_op(o_alu_op),
        .i_alu_result(i_alu_result), .o_busy(o_busy)
    );

    task automatic send_byte(input logic [7:0] b);
        @(negedge i_clk);
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        @(negedge i_clk);
        i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [7:0] op);
        for (int i = 0; i < 4; i++) send_byte(a[i*8 +: 8]);
        for (int i = 0; i < 4; i++) send_byte(b[i*8 +: 8]);
        send_byte(op);
    endtask

    // Collects four transmitted bytes; holds i_tx_done off for done_delay cycles per byte.
    task automatic collect_tx(input int done_delay, input bit inject,
                              output logic [31:0] word, output int first_lat);
        int         waited;
        bit         seen;
        bit         stable;
        logic [7:0] d;
        word      = '0;
        first_lat = -1;
        for (int k = 0; k < 4; k++) begin
            seen   = 1'b0;
            waited = 0;
            for (int i = 1; i <= 20 && !seen; i++) begin
                @(negedge i_clk);
                if (o_tx_start === 1'b1) begin
                    seen   = 1'b1;
                    waited = i;
                end
            end
            checks++;
            if (!seen) begin
                errors++;
                $display("FAIL tx_start_timeout byte %0d: got no pulse, required a pulse within 20 cycles", k);
                return;
            end
            if (k == 0) first_lat = waited;
            d = o_tx_data;
            word[k*8 +: 8] = d;
            stable = 1'b1;
            for (int c = 0; c <= done_delay; c++) begin
                @(negedge i_clk);
                if (inject && c == 1) begin
                    i_rx_data  = 8'hAA;
                    i_rx_valid = 1'b1;
                end else begin
                    i_rx_valid = 1'b0;
                end
                if (o_tx_start !== 1'b0 || o_tx_data !== d) stable = 1'b0;
            end
            i_tx_done = 1'b1;
            if (inject) begin
                i_rx_data  = 8'h55;
                i_rx_valid = 1'b1;
            end
            @(negedge i_clk);
            i_tx_done  = 1'b0;
            i_rx_valid = 1'b0;
            checks++;
            if (!stable) begin
                errors++;
                $display("FAIL tx_pulse_stable byte %0d: got extra pulse or data change, required one 1-cycle pulse with data %h held", k, d);
            end
        end
    endtask

    task automatic test_reset;
        #12;
        checks++; if (o_alu_a !== 32'h0) begin errors++; $display("FAIL reset_alu_a: got %h required 0", o_alu_a); end
        checks++; if (o_alu_b !== 32'h0) begin errors++; $display("FAIL reset_alu_b: got %h required 0", o_alu_b); end
        checks++; if (o_alu_op !== 6'h0) begin errors++; $display("FAIL reset_alu_op: got %h required 0", o_alu_op); end
        checks++; if ({o_tx_data, o_tx_start} !== 9'h0) begin errors++; $display("FAIL reset_tx: got %h/%b required 0/0", o_tx_data, o_tx_start); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
    endtask

    task automatic test_add;
        logic [31:0] w;
        int          lat;
        send_frame(32'd5, 32'd3, 8'h20);
        checks++; if (o_alu_a !== 32'd5) begin errors++; $display("FAIL add_alu_a: got %h required 5", o_alu_a); end
        checks++; if (o_alu_b !== 32'd3) begin errors++; $display("FAIL add_alu_b: got %h required 3", o_alu_b); end
        checks++; if (o_alu_op !== 6'h20) begin errors++; $display("FAIL add_alu_op: got %h required 20", o_alu_op); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL add_busy_during: got %b required 1", o_busy); end
        collect_tx(2, 1'b0, w, lat);
        checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d required 2", lat); end
        checks++; if (w !== 32'd8) begin errors++; $display("FAIL add_result: got %h required 00000008", w); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL add_busy_after: got %b required 0", o_busy); end
    endtask

    task automatic test_slt_op_mask;
        logic [31:0] w;
        int          lat;
        send_frame(32'hFFFF_FFFE, 32'h0000_0001, 8'hEA);
        checks++; if (o_alu_op !== 6'h2A) begin errors++; $display("FAIL slt_op_mask: got %h required 2a", o_alu_op); end
        collect_tx(3, 1'b1, w, lat);
        checks++; if (w !== 32'd1) begin errors++; $display("FAIL slt_result: got %h required 00000001", w); end
        checks++; if (o_alu_a !== 32'hFFFF_FFFE) begin errors++; $display("FAIL slt_rx_dropped: got a=%h required fffffffe", o_alu_a); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL slt_busy_after: got %b required 0", o_busy); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] w;
        int          lat;
        @(negedge i_clk);
        i_tx_done = 1'b1;
        @(negedge i_clk);
        i_tx_done = 1'b0;
        @(negedge i_clk);
        checks++; if (o_busy !== 1'b0 || o_tx_start !== 1'b0) begin
            errors++; $display("FAIL stray_tx_done: got busy=%b start=%b required 0/0", o_busy, o_tx_start);
        end
        send_frame(32'h10, 32'h4, 8'h02);
        collect_tx(1, 1'b0, w, lat);
        checks++; if (w !== 32'd1) begin errors++; $display("FAIL srl_result: got %h required 00000001", w); end
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] w;
        int          lat;
        for (int i = 0; i < 4; i++) send_byte(8'h44 - 8'(i * 8'h11));
        send_byte(8'hEF);
        send_byte(8'hBE);
        checks++; if (o_alu_a !== 32'h1122_3344) begin errors++; $display("FAIL partial_a: got %h required 11223344", o_alu_a); end
        checks++; if (o_alu_b !== 32'h0000_BEEF) begin errors++; $display("FAIL partial_b: got %h required 0000beef", o_alu_b); end
        @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        checks++; if ({o_alu_a, o_alu_b} !== 64'h0) begin errors++; $display("FAIL midrst_operands: got %h/%h required 0/0", o_alu_a, o_alu_b); end
        checks++; if (o_busy !== 1'b0 || o_alu_op !== 6'h0) begin errors++; $display("FAIL midrst_busy_op: got %b/%h required 0/0", o_busy, o_alu_op); end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        send_frame(32'd7, 32'd9, 8'h22);
        collect_tx(0, 1'b0, w, lat);
        checks++; if (w !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_after_reset: got %h required fffffffe", w); end
    endtask

    task automatic test_slow_tx;
        logic [31:0] w;
        int          lat;
        send_frame(32'h0000_1234, 32'h0000_0FF0, 8'h25);
        collect_tx(50, 1'b0, w, lat);
        checks++; if (w !== 32'h0000_1FF4) begin errors++; $display("FAIL slow_or_result: got %h required 00001ff4", w); end
    endtask

`ifdef ALU_UART_IF_TIMEOUT_EN
    task automatic test_timeout;
        logic [31:0] w;
        int          lat;
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (25) @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL timeout_idle: got busy=%b required 0", o_busy); end
        send_frame(32'd6, 32'd7, 8'h24);
        checks++; if (o_alu_a !== 32'd6) begin errors++; $display("FAIL timeout_realign_a: got %h required 6", o_alu_a); end
        collect_tx(1, 1'b0, w, lat);
        checks++; if (w !== 32'd6) begin errors++; $display("FAIL timeout_and_result: got %h required 00000006", w); end
    endtask
`endif

    initial begin
        test_reset;
        test_add;
        test_slt_op_mask;
        test_back_to_back;
        test_reset_mid_frame;
        test_slow_tx;
`ifdef ALU_UART_IF_TIMEOUT_EN
        test_timeout;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "time limit");
    end

endmodule
